// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared next-PC mode encodings and default vectors for the PC unit
package pc_pkg;

    // Next-PC mode encodings driven by the decoder.
    typedef enum logic [1:0] {
        SEL_SEQ = 2'b00,
        SEL_BR  = 2'b01,
        SEL_JMP = 2'b10,
        SEL_REG = 2'b11
    } sel_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0080;

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack with overwrite-oldest on overflow
//
// Ports:
//   clk, rst_n  : falling-edge clock, asynchronous active-low reset
//   push        : write din at top+1 (or replace the top when popping at the same time)
//   pop         : move top down by one; ignored when empty
//   din         : return address to push
//   top         : entry at the top pointer (meaningless when empty)
//   empty, full : entry count is 0 / equals DEPTH
module ras_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    top_ptr;
    logic [PW-1:0]    nxt_ptr;
    logic [CW-1:0]    count;
    logic             replace;

    assign nxt_ptr = top_ptr + 1'b1;
    assign empty   = (count == '0);
    assign full    = (count == CNT_MAX);
    assign top     = mem[top_ptr];

    // Pop-then-push on a non-empty stack collapses to overwriting the top in
    // place. On an empty stack the pop is a no-op, so it is a plain push.
    assign replace = push && pop && !empty;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_ptr <= '0;
            count   <= '0;
        end else if (replace) begin
            top_ptr <= top_ptr;
            count   <= count;
        end else if (push) begin
            // When full, the pointer wraps onto the oldest entry and the
            // count saturates.
            top_ptr <= nxt_ptr;
            if (!full) begin
                count <= count + 1'b1;
            end
        end else if (pop && !empty) begin
            top_ptr <= top_ptr - 1'b1;
            count   <= count - 1'b1;
        end
    end

    // Entry contents need no reset; validity is tracked by count.
    always_ff @(negedge clk) begin
        if (replace) begin
            mem[top_ptr] <= din;
        end else if (push) begin
            mem[nxt_ptr] <= din;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with next-PC mux, return-address stack and misalign fault
//
// Ports:
//   clk, rst_n : falling-edge clock, asynchronous active-low reset
//   en         : update enable; 0 holds PC, RAS and fault
//   sel        : next-PC mode (seq / branch / jump / register jump)
//   taken, imm : branch condition and signed word offset
//   jtarget    : jump word index
//   rs_val     : register-jump target
//   call, ret  : push return address / pop return address
//   pcout      : current PC;  pcplus : pcout + STEP
//   ras_empty, ras_full : RAS occupancy;  fault : sticky misaligned-target flag
module pc_unit import pc_pkg::*; #(
    parameter int               WIDTH     = 32,
    parameter int               STEP      = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       sel,
    input  logic             taken,
    input  logic [15:0]      imm,
    input  logic [25:0]      jtarget,
    input  logic [WIDTH-1:0] rs_val,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pcout,
    output logic [WIDTH-1:0] pcplus,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             fault
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    sel_e             sel_m;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] br_off;
    logic [WIDTH-1:0] br_tgt;
    logic [WIDTH-1:0] jmp_tgt;
    logic [WIDTH-1:0] reg_tgt;
    logic [WIDTH-1:0] ras_top;
    logic             is_reg;
    logic             misalign;
    logic             ras_push;
    logic             ras_pop;

    assign sel_m   = sel_e'(sel);
    assign pcout   = pc_q;
    assign pcplus  = pc_q + STEP_W;

    assign br_off  = {{(WIDTH-18){imm[15]}}, imm, 2'b00};
    assign br_tgt  = pcplus + br_off;
    assign jmp_tgt = {pcplus[WIDTH-1:28], jtarget, 2'b00};

    // An empty RAS makes a return fall back to the register value.
    assign reg_tgt  = (ret && !ras_empty) ? ras_top : rs_val;
    assign is_reg   = (sel_m == SEL_REG);
    assign misalign = is_reg && (reg_tgt[1:0] != 2'b00);

    always_comb begin
        pc_d = pcplus;
        case (sel_m)
            SEL_SEQ: pc_d = pcplus;
            SEL_BR:  pc_d = taken ? br_tgt : pcplus;
            SEL_JMP: pc_d = jmp_tgt;
            SEL_REG: pc_d = misalign ? EXC_VEC : reg_tgt;
            default: pc_d = pcplus;
        endcase
    end

    // A faulting register jump leaves the stack untouched.
    assign ras_push = en && !misalign && call && (sel_m == SEL_JMP || is_reg);
    assign ras_pop  = en && !misalign && ret && is_reg;

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pcplus),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_VEC;
            fault <= 1'b0;
        end else if (en) begin
            pc_q <= pc_d;
            if (misalign) begin
                fault <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - scoreboard testbench for pc_unit
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  sel;
    logic        taken;
    logic [15:0] imm;
    logic [25:0] jtarget;
    logic [31:0] rs_val;
    logic        call;
    logic        ret;
    logic [31:0] pcout;
    logic [31:0] pcplus;
    logic        ras_empty;
    logic        ras_full;
    logic        fault;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        emp;
        logic        ful;
        logic        flt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    pc_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sel       (sel),
        .taken     (taken),
        .imm       (imm),
        .jtarget   (jtarget),
        .rs_val    (rs_val),
        .call      (call),
        .ret       (ret),
        .pcout     (pcout),
        .pcplus    (pcplus),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
        end
    endtask

    // Monitor: pops one expectation per clock (sampled 1 ns after the rising
    // edge, away from the falling update edge) or right after a reset assert.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.name, "pcout",  pcout,            e.pc);
                chk(e.name, "pcplus", pcplus,           e.pc + 32'd4);
                chk(e.name, "empty",  {31'd0, ras_empty}, {31'd0, e.emp});
                chk(e.name, "full",   {31'd0, ras_full},  {31'd0, e.ful});
                chk(e.name, "fault",  {31'd0, fault},     {31'd0, e.flt});
            end
        end
    end

    task automatic push_exp(input string nm, input logic [31:0] epc, input logic ee,
                            input logic ef, input logic efl);
        exp_t e;
        e.name = nm; e.pc = epc; e.emp = ee; e.ful = ef; e.flt = efl;
        q.push_back(e);
    endtask

    // Drive one instruction; the expectation is the state after the next falling edge.
    task automatic cyc(input string nm, input logic e, input logic [1:0] s, input logic tk,
                       input logic [15:0] im, input logic [25:0] jt, input logic [31:0] rs,
                       input logic c, input logic r, input logic [31:0] epc,
                       input logic ee, input logic ef, input logic efl);
        @(posedge clk);
        #2;
        en = e; sel = s; taken = tk; imm = im; jtarget = jt; rs_val = rs; call = c; ret = r;
        push_exp(nm, epc, ee, ef, efl);
    endtask

    // Register jump used to place the PC at an arbitrary aligned address.
    task automatic go(input string nm, input logic [31:0] tgt, input logic ee, input logic ef, input logic efl);
        cyc(nm, 1'b1, 2'b11, 1'b0, 16'h0, 26'h0, tgt, 1'b0, 1'b0, tgt, ee, ef, efl);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; sel = 2'b00; taken = 1'b0; imm = 16'h0;
        jtarget = 26'h0; rs_val = 32'h0; call = 1'b0; ret = 1'b0;

        // Reset state, then sequential stepping and stall
        cyc("reset", 1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #2; rst_n = 1'b1;
        en = 1'b1;
        push_exp("seq1", 32'h4, 1'b1, 1'b0, 1'b0);
        cyc("seq2",   1'b1, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 32'h8, 1'b1, 1'b0, 1'b0);
        cyc("seq3",   1'b1, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 32'hC, 1'b1, 1'b0, 1'b0);
        cyc("stall1", 1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 32'hC, 1'b1, 1'b0, 1'b0);
        cyc("stall2", 1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 32'hC, 1'b1, 1'b0, 1'b0);
        // Stalled call must not push
        cyc("stallcall", 1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h40, 1'b1, 1'b0, 32'hC, 1'b1, 1'b0, 1'b0);

        // Branches
        go("go100a", 32'h100, 1'b1, 1'b0, 1'b0);
        cyc("br_taken", 1'b1, 2'b01, 1'b1, 16'hFFFE, 26'h0, 32'h0, 1'b0, 1'b0, 32'h0FC, 1'b1, 1'b0, 1'b0);
        go("go100b", 32'h100, 1'b1, 1'b0, 1'b0);
        cyc("br_not",   1'b1, 2'b01, 1'b0, 16'hFFFE, 26'h0, 32'h0, 1'b0, 1'b0, 32'h104, 1'b1, 1'b0, 1'b0);
        go("gotop", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
        cyc("br_wrap",  1'b1, 2'b01, 1'b1, 16'h0001, 26'h0, 32'h0, 1'b0, 1'b0, 32'h4, 1'b1, 1'b0, 1'b0);

        // Jump-and-link then return
        go("go1000", 32'h1000_0010, 1'b1, 1'b0, 1'b0);
        cyc("jal",  1'b1, 2'b10, 1'b0, 16'h0, 26'h40, 32'h0, 1'b1, 1'b0, 32'h1000_0100, 1'b0, 1'b0, 1'b0);
        cyc("jret", 1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'hDEAD_BEE0, 1'b0, 1'b1, 32'h1000_0014, 1'b1, 1'b0, 1'b0);

        // Five calls into a 4-deep stack, then five returns
        go("go0", 32'h0, 1'b1, 1'b0, 1'b0);
        cyc("call0",  1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h10,  1'b1, 1'b0, 32'h10,  1'b0, 1'b0, 1'b0);
        cyc("call10", 1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h20,  1'b1, 1'b0, 32'h20,  1'b0, 1'b0, 1'b0);
        cyc("call20", 1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h30,  1'b1, 1'b0, 32'h30,  1'b0, 1'b0, 1'b0);
        cyc("call30", 1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h40,  1'b1, 1'b0, 32'h40,  1'b0, 1'b1, 1'b0);
        cyc("call40", 1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h200, 1'b1, 1'b0, 32'h200, 1'b0, 1'b1, 1'b0);
        cyc("ret1", 1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h300, 1'b0, 1'b1, 32'h44,  1'b0, 1'b0, 1'b0);
        cyc("ret2", 1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h300, 1'b0, 1'b1, 32'h34,  1'b0, 1'b0, 1'b0);
        cyc("ret3", 1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h300, 1'b0, 1'b1, 32'h24,  1'b0, 1'b0, 1'b0);
        cyc("ret4", 1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h300, 1'b0, 1'b1, 32'h14,  1'b1, 1'b0, 1'b0);
        cyc("ret5", 1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h300, 1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0);

        // Misaligned register jump: fault, RAS untouched despite CALL
        cyc("jal2",  1'b1, 2'b10, 1'b0, 16'h0, 26'h50, 32'h0, 1'b1, 1'b0, 32'h140, 1'b0, 1'b0, 1'b0);
        cyc("misal", 1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h202, 1'b1, 1'b0, 32'h80, 1'b0, 1'b0, 1'b1);
        cyc("ret_after_fault", 1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h500, 1'b0, 1'b1, 32'h304, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset mid-cycle, checked before the next falling edge
        @(posedge clk); #2;
        push_exp("async_rst", 32'h0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        cyc("rst_hold", 1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h700, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #2; rst_n = 1'b1;
        sel = 2'b11; call = 1'b1; ret = 1'b0; rs_val = 32'h600; en = 1'b1;
        push_exp("call_a", 32'h600, 1'b0, 1'b0, 1'b0);

        // CALL+RET with one entry: replace top, count stays 1
        cyc("callret", 1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h700, 1'b1, 1'b1, 32'h4,   1'b0, 1'b0, 1'b0);
        cyc("ret_new", 1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h800, 1'b0, 1'b1, 32'h604, 1'b1, 1'b0, 1'b0);
        cyc("ret_emp", 1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h900, 1'b0, 1'b1, 32'h900, 1'b1, 1'b0, 1'b0);
        // CALL+RET on an empty stack: target RS_VAL, count becomes 1
        cyc("callret_emp", 1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'hA00, 1'b1, 1'b1, 32'hA00, 1'b0, 1'b0, 1'b0);
        cyc("ret_904",     1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'hB00, 1'b0, 1'b1, 32'h904, 1'b1, 1'b0, 1'b0);
        // Ignored CALL with SEL=00 and RET with SEL=10
        cyc("seq_call", 1'b1, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b0, 32'h908, 1'b1, 1'b0, 1'b0);
        cyc("jmp_ret",  1'b1, 2'b10, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1, 32'h0,   1'b1, 1'b0, 1'b0);

        @(posedge clk); #2;
        en = 1'b0; call = 1'b0; ret = 1'b0;
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            @(posedge clk); #3;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
